if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage pipe. Owns the PC, drives the synchronous
//  instruction memory (1-cycle read latency), buffers returned words in a small queue,
//  presents {instr, pc} to the decode stage over a valid/ready handshake (decode hosts
//  the imm generator). Accepts redirects (branch/jump) from EX; a redirect flushes the fetch.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC issued on the first cycle after reset release
//  FQ_DEPTH   2              fetch-queue entries (>=2); power of two
// PORTS
//  clk            in   1   clock, rising edge
//  rstn           in   1   asynchronous active-low reset
//  imem_en        out  1   read request this cycle
//  imem_addr      out  32  byte address of request; bits[1:0] always 0
//  imem_rdata     in   32  instruction word, valid the cycle after imem_en
//  redirect_valid in   1   EX requests PC change this cycle
//  redirect_pc    in   32  target PC; bits[1:0] ignored (forced 0)
//  id_valid       out  1   queue head holds a valid instruction
//  id_ready       in   1   decode accepts head this cycle (0 = stall)
//  id_instr       out  32  head instruction word
//  id_pc          out  32  head PC
// BEHAVIOUR
//  - Reset (async, rstn=0): pc_q=RESET_PC, queue empty (count=0), inflight=0, drop=0;
//    outputs imem_en=0, id_valid=0, id_instr=`INSTR_NOP, id_pc=0.
//  - deq = id_valid & id_ready. issue = ~redirect_valid & (count + inflight - deq < FQ_DEPTH).
//    imem_en=issue (combinational, includes id_ready path); imem_addr=pc_q.
//  - On issue: pc_q <= pc_q + 4 (mod 2^32: 32'hFFFF_FFFC wraps to 0); inflight <= 1,
//    and the tag pc of the request is held in req_pc_q.
//  - Response: cycle after issue, if inflight & ~drop: enqueue {imem_rdata, req_pc_q} at
//    that edge. Credit rule guarantees no enqueue into a full queue (assert in sim).
//  - Latency: reset release -> cycle0 imem_en=1 addr=RESET_PC; cycle1 rdata; cycle2
//    id_valid=1. Steady state 1 instr/cycle with id_ready=1.
//  - Stall: id_ready=0 holds id_instr/id_pc stable; fetch stops once credits are used.
//  - Enqueue and dequeue same edge: count unchanged, both take effect.
//  - Redirect (highest priority): at the edge, pc_q <= {redirect_pc[31:2],2'b00}, queue
//    cleared, count=0; if a request is in flight its response next cycle is discarded
//    (drop <= inflight). No issue in the redirect cycle; first new-target issue cycle+1.
//    A dequeue coinciding with redirect is void: decode is flushed by the same redirect.
//  - Back-to-back redirects: last one wins; drop only suppresses the single response due.
//  - Reset asserted mid-operation: all state returns to reset values immediately;
//    any memory response after release is ignored (inflight=0).
//  - id_valid = (count != 0); head fields combinational from queue storage;
//    id_instr = `INSTR_NOP when empty.
// STRUCTURE
//  - macrodefine.v gains: `INSTR_NOP (32'h0000_0013), `RESET_PC_DEFAULT.
//  - Sub-module fetch_queue: sync FIFO, FQ_DEPTH x 64b {instr,pc}, push/pop/flush,
//    count output, async active-low reset; storage need not reset (head muxed to NOP).
//  - Top: PC register, inflight/drop flags, req_pc_q, credit logic.
// TESTING
//  1 Reset release, id_ready=1, imem returns addr as data -> imem_addr 0,4,8..;
//    id_pc 0 in cycle2, then +4 each cycle, no gaps.
//  2 id_ready=0 for 5 cycles from cycle3 -> id_pc stable, imem_en drops after credits
//    exhausted, no word lost/duplicated on release.
//  3 redirect_valid=1, redirect_pc=32'h100 while a request is in flight -> next response
//    dropped, queue empty, imem_addr=32'h100 one cycle later, id_pc=32'h100 two after.
//  4 redirect_pc=32'h203 -> fetch from 32'h200.
//  5 RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
//  6 rstn pulsed low mid-stream with queue full -> id_valid=0 immediately, refetch
//    from RESET_PC; scoreboard confirms in-order, exactly-once delivery throughout.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The fetch-to-decode bundle is a packed {instr, pc} record.
package if_fetch_stage_pkg;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } if_id_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory port and fetch-to-decode handshake.
// Fetch is the master on both.
interface if_fetch_imem_if;
  logic        en;
  logic [31:0] addr;
  logic [31:0] rdata;

  modport master (output en, output addr, input rdata);
  modport slave  (input en, input addr, output rdata);
endinterface

interface if_fetch_id_if;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;

  modport master (output valid, output instr, output pc, input ready);
  modport slave  (input valid, input instr, input pc, output ready);
endinterface

// File: rtl/if_fetch_stage_fetch_queue.sv
// Small synchronous FIFO of fetched {instr, pc} words.
// Flush wins over push/pop; storage is not reset.
module fetch_queue
  import if_fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  if_id_t        din,
  output if_id_t        head,
  output logic [CW-1:0] count
);

  if_id_t          mem [DEPTH];
  logic [AW-1:0]   wr_q;
  logic [AW-1:0]   rd_q;
  logic [CW-1:0]   count_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push && !pop)
        assert (count_q < CW'(DEPTH));
      if (push)
        wr_q <= wr_q + 1'b1;
      if (pop)
        rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_q] <= din;
  end

  assign head  = mem[rd_q];
  assign count = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: PC, imem request/response tracking, credit-based
// issue into the fetch queue, redirect flush.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          FQ_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  if_fetch_imem_if.master       imem,
  if_fetch_id_if.master         id
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam int UW = CW + 1;

  logic [31:0]   pc_q;
  logic [31:0]   req_pc_q;
  logic          inflight_q;
  logic          drop_q;
  logic [CW-1:0] count;
  logic [UW-1:0] used;
  logic          deq;
  logic          issue;
  logic          push;
  if_id_t        head;
  if_id_t        din;

  assign deq  = id.valid & id.ready;
  // Slots already promised: queued words plus the response on its way.
  assign used = UW'(count) + UW'(inflight_q) - UW'(deq);

  assign issue = rstn & ~redirect_valid
               & (used < UW'(FQ_DEPTH));
  assign push  = inflight_q & ~drop_q & ~redirect_valid;

  assign imem.en   = issue;
  assign imem.addr = pc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else if (redirect_valid) begin
      pc_q       <= {redirect_pc[31:2], 2'b00};
      inflight_q <= 1'b0;
      drop_q     <= inflight_q;
    end else begin
      drop_q     <= 1'b0;
      inflight_q <= issue;
      if (issue) begin
        pc_q     <= pc_q + 32'd4;
        req_pc_q <= pc_q;
      end
    end
  end

  assign din = '{instr: imem.rdata, pc: req_pc_q};

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (deq & ~redirect_valid),
    .flush (redirect_valid),
    .din   (din),
    .head  (head),
    .count (count)
  );

  assign id.valid = (count != '0);
  assign id.instr = id.valid ? head.instr : INSTR_NOP;
  assign id.pc    = id.valid ? head.pc : 32'h0;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed latency/stall/redirect/reset
// sequences plus random traffic against a PC-stream scoreboard.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        rv1 = 1'b0;
  logic [31:0] rp1 = 32'h0;

  int total = 0;
  int bad   = 0;
  int delivered = 0;

  if_fetch_imem_if im0 ();
  if_fetch_id_if   id0 ();
  if_fetch_imem_if im1 ();
  if_fetch_id_if   id1 ();

  if_fetch_stage #(.RESET_PC(RPC0), .FQ_DEPTH(2)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (im0),
    .id             (id0)
  );

  if_fetch_stage #(.RESET_PC(RPC1), .FQ_DEPTH(2)) dut_hi (
    .clk            (clk),
    .rstn           (rstn),
    .redirect_valid (rv1),
    .redirect_pc    (rp1),
    .imem           (im1),
    .id             (id1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (im0.en) im0.rdata <= mem_word(im0.addr);
    if (im1.en) im1.rdata <= mem_word(im1.addr);
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Scoreboard: decode must see an unbroken +4 PC stream from
  // the reset PC or the last redirect target, each word once.
  logic [31:0] exp_pc = RPC0;
  logic        stall_q = 1'b0;
  logic [31:0] hold_pc, hold_instr;

  always @(negedge clk) begin
    if (!rstn) begin
      exp_pc  = RPC0;
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("stall_valid", 32'(id0.valid), 32'd1);
        chk("stall_pc", id0.pc, hold_pc);
        chk("stall_instr", id0.instr, hold_instr);
      end
      if (im0.en)
        chk("addr_align", 32'(im0.addr[1:0]), 32'd0);
      if (redirect_valid) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (id0.valid && id0.ready) begin
        chk("sb_pc", id0.pc, exp_pc);
        chk("sb_instr", id0.instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      stall_q    = id0.valid && !id0.ready && !redirect_valid;
      hold_pc    = id0.pc;
      hold_instr = id0.instr;
    end
  end

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
  } redir_vec_t;

  redir_vec_t vecs [5];

  initial begin
    vecs[0] = '{32'h0000_0100, 32'h0000_0100};
    vecs[1] = '{32'h0000_0203, 32'h0000_0200};
    vecs[2] = '{32'h0000_0007, 32'h0000_0004};
    vecs[3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC};
    vecs[4] = '{32'h0000_1001, 32'h0000_1000};

    rstn = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    id0.ready = 1'b1;
    id1.ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en", 32'(im0.en), 32'd0);
    chk("rst_valid", 32'(id0.valid), 32'd0);
    chk("rst_instr", id0.instr, INSTR_NOP);
    chk("rst_pc", id0.pc, 32'h0);
    chk("rst_en_hi", 32'(im1.en), 32'd0);

    // Latency from reset release, both reset PCs.
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    chk("c0_en", 32'(im0.en), 32'd1);
    chk("c0_addr", im0.addr, RPC0);
    chk("c0_valid", 32'(id0.valid), 32'd0);
    chk("hi_c0_addr", im1.addr, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("c1_addr", im0.addr, 32'h4);
    chk("c1_valid", 32'(id0.valid), 32'd0);
    chk("hi_c1_addr", im1.addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("c2_valid", 32'(id0.valid), 32'd1);
    chk("c2_pc", id0.pc, RPC0);
    chk("hi_c2_addr", im1.addr, 32'h0);
    chk("hi_c2_pc", id1.pc, 32'hFFFF_FFF8);

    // Stall: five cycles of backpressure from cycle 3.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 id0.ready = 1'b0;
      @(negedge clk);
    end
    chk("stall_en", 32'(im0.en), 32'd0);
    chk("stall_head", id0.pc, 32'h4);
    @(posedge clk); #1 id0.ready = 1'b1;
    repeat (6) @(negedge clk);

    // Redirect table: target alignment, drop and refetch latency.
    for (int v = 0; v < 5; v++) begin
      @(posedge clk); #1;
      redirect_valid = 1'b1;
      redirect_pc = vecs[v].rpc;
      @(negedge clk);
      chk("rd_en_blk", 32'(im0.en), 32'd0);
      @(posedge clk); #1 redirect_valid = 1'b0;
      @(negedge clk);
      chk("rd_b_valid", 32'(id0.valid), 32'd0);
      chk("rd_b_instr", id0.instr, INSTR_NOP);
      chk("rd_b_en", 32'(im0.en), 32'd1);
      chk("rd_b_addr", im0.addr, vecs[v].exp_addr);
      @(negedge clk);
      chk("rd_c_valid", 32'(id0.valid), 32'd0);
      chk("rd_c_addr", im0.addr, vecs[v].exp_addr + 32'd4);
      @(negedge clk);
      chk("rd_d_valid", 32'(id0.valid), 32'd1);
      chk("rd_d_pc", id0.pc, vecs[v].exp_addr);
      chk("rd_d_instr", id0.instr, mem_word(vecs[v].exp_addr));
      repeat (3) @(negedge clk);
    end

    // Back-to-back redirects: the later target wins.
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    @(posedge clk); #1 redirect_pc = 32'h404;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    chk("b2b_addr", im0.addr, 32'h404);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_pc", id0.pc, 32'h404);

    // Reset with a full queue.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 id0.ready = 1'b0;
    end
    @(negedge clk);
    chk("full_valid", 32'(id0.valid), 32'd1);
    chk("full_en", 32'(im0.en), 32'd0);
    @(posedge clk); #1 rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(id0.valid), 32'd0);
    chk("mid_rst_en", 32'(im0.en), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    id0.ready = 1'b1;
    rstn = 1'b1;
    @(negedge clk);
    chk("rr_c0_addr", im0.addr, RPC0);
    chk("rr_c0_valid", 32'(id0.valid), 32'd0);
    @(negedge clk);
    chk("rr_c1_valid", 32'(id0.valid), 32'd0);
    @(negedge clk);
    chk("rr_c2_pc", id0.pc, RPC0);
    chk("rr_c2_instr", id0.instr, mem_word(RPC0));

    // Random backpressure and redirects.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      id0.ready = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc = $urandom_range(32'hFFF);
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    id0.ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("throughput", 32'(delivered > 800), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
